sumador_arbitro: RTL and testbench

SUMADOR_ARBITRO -- requirements
Module: sumador_arbitro

---
 rtl/sumador_arbitro.sv | 149 ++++++++++++++
 tb/tb_sumador_arbitro.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_arbitro.sv
// rtl/sumador_arbitro.sv - two-requester round-robin front end for one shared external 8-bit ripple adder
// Operands are registered onto the adder on accept; the sum is captured after SETTLE_CYC cycles.
module sumador_arbitro #(
    parameter int SETTLE_CYC = 2,
    parameter int PwrC       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_ci,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_ci,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_s,
    output logic       rsp_co,
    input  logic       rsp_ready,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_ci,
    input  logic [7:0] add_s,
    input  logic       add_co,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       id_q, id_d;
    logic [7:0] add_a_q, add_a_d;
    logic [7:0] add_b_q, add_b_d;
    logic       add_ci_q, add_ci_d;
    logic [7:0] s_q, s_d;
    logic       co_q, co_d;
    logic       grant0, grant1;
    logic       unused_pwr;

    assign unused_pwr = (PwrC != 0);

    // Grant is gated by reset so nothing can be accepted on a reset edge.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            add_a_q      <= 8'd0;
            add_b_q      <= 8'd0;
            add_ci_q     <= 1'b0;
            s_q          <= 8'd0;
            co_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_ci_q     <= add_ci_d;
            s_q          <= s_d;
            co_q         <= co_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_ci_d     = add_ci_q;
        s_d          = s_q;
        co_d         = co_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = SETTLE;
                    cnt_d        = CNT_LOAD;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    add_a_d      = grant1 ? req1_a  : req0_a;
                    add_b_d      = grant1 ? req1_b  : req0_b;
                    add_ci_d     = grant1 ? req1_ci : req0_ci;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    s_d     = add_s;
                    co_d    = add_co;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    assign rsp_id = id_q;
    assign rsp_s  = s_q;
    assign rsp_co = co_q;
    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign add_ci = add_ci_q;

endmodule

// File: tb/tb_sumador_arbitro.sv
// tb/tb_sumador_arbitro.sv - scoreboard bench for sumador_arbitro at SETTLE_CYC 2, 1 and 15
// Each instance drives its own behavioural ripple adder.
module tb_sumador_arbitro;

    localparam int N = 3;

    typedef struct {
        int         k;
        logic       id;
        logic [7:0] s;
        logic       co;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       v0 [N], v1 [N], ci0 [N], ci1 [N], r0 [N], r1 [N];
    logic       rv [N], rid [N], rco [N], rr [N], aci [N], aco [N], bsy [N];
    logic [7:0] a0 [N], b0 [N], a1 [N], b1 [N], rs [N], aa [N], ab [N], as_ [N];

    exp_t        sbq [$];
    int          glog [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          nrsp [N];
    logic        lg [N], idle_exp [N], prev_acc [N], acc_now [N], acc_who [N];
    logic        prev_rst = 1'b1;
    logic [16:0] prev_add [N];
    logic [7:0]  last_s [N];
    logic        last_co [N], last_id [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        sumador_arbitro #(
            .SETTLE_CYC(k == 0 ? 2 : (k == 1 ? 1 : 15)),
            .PwrC(k)
        ) u_dut (
            .clk(clk), .reset(reset),
            .req0_valid(v0[k]), .req0_a(a0[k]), .req0_b(b0[k]), .req0_ci(ci0[k]), .req0_ready(r0[k]),
            .req1_valid(v1[k]), .req1_a(a1[k]), .req1_b(b1[k]), .req1_ci(ci1[k]), .req1_ready(r1[k]),
            .rsp_valid(rv[k]), .rsp_id(rid[k]), .rsp_s(rs[k]), .rsp_co(rco[k]), .rsp_ready(rr[k]),
            .add_a(aa[k]), .add_b(ab[k]), .add_ci(aci[k]), .add_s(as_[k]), .add_co(aco[k]),
            .busy(bsy[k])
        );
        assign {aco[k], as_[k]} = {1'b0, aa[k]} + {1'b0, ab[k]} + {8'd0, aci[k]};
    end

    function automatic int sc_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic int find_k(input int k);
        foreach (sbq[i]) if (sbq[i].k == k) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        for (int k = 0; k < N; k++) begin
            int          idx;
            logic        exp_rv, e0, e1;
            logic [8:0]  t;
            logic [16:0] addv;
            acc_now[k] = 1'b0;
            addv = {aa[k], ab[k], aci[k]};
            if (reset) begin
                chk("rst_ready0", r0[k], 0);
                chk("rst_ready1", r1[k], 0);
                for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].k == k) sbq.delete(i);
                lg[k] = 1'b1;
                idle_exp[k] = 1'b1;
            end else begin
                if (!prev_rst && !prev_acc[k]) chk("add_hold", addv, prev_add[k]);
                chk("busy", bsy[k], !idle_exp[k]);
                e0 = idle_exp[k] && v0[k] && (!v1[k] || lg[k]);
                e1 = idle_exp[k] && v1[k] && (!v0[k] || !lg[k]);
                chk("ready_mutex", r0[k] & r1[k], 0);
                chk("ready0", r0[k], e0);
                chk("ready1", r1[k], e1);
                if (v0[k] && r0[k]) begin
                    t = {1'b0, a0[k]} + {1'b0, b0[k]} + {8'd0, ci0[k]};
                    sbq.push_back('{k: k, id: 1'b0, s: t[7:0], co: t[8], cyc: cyc_n});
                    lg[k] = 1'b0; acc_now[k] = 1'b1; acc_who[k] = 1'b0;
                    if (k == 0) glog.push_back(0);
                end
                if (v1[k] && r1[k]) begin
                    t = {1'b0, a1[k]} + {1'b0, b1[k]} + {8'd0, ci1[k]};
                    sbq.push_back('{k: k, id: 1'b1, s: t[7:0], co: t[8], cyc: cyc_n});
                    lg[k] = 1'b1; acc_now[k] = 1'b1; acc_who[k] = 1'b1;
                    if (k == 0) glog.push_back(1);
                end
                idx = find_k(k);
                exp_rv = 1'b0;
                if (idx >= 0) exp_rv = (cyc_n >= sbq[idx].cyc + sc_of(k) + 1);
                chk("rsp_valid", rv[k], exp_rv);
                if (exp_rv) begin
                    chk("rsp_s", rs[k], sbq[idx].s);
                    chk("rsp_co", rco[k], sbq[idx].co);
                    chk("rsp_id", rid[k], sbq[idx].id);
                    if (rr[k]) begin
                        last_s[k] = rs[k]; last_co[k] = rco[k]; last_id[k] = rid[k];
                        sbq.delete(idx);
                        nrsp[k]++;
                        idle_exp[k] = 1'b1;
                    end
                end
                if (acc_now[k]) idle_exp[k] = 1'b0;
            end
            prev_add[k] = addv;
            prev_acc[k] = acc_now[k];
        end
        prev_rst = reset;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic id, input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic got;
        got = 1'b0;
        if (!id) begin a0[k] = a; b0[k] = b; ci0[k] = ci; v0[k] = 1'b1; end
        else     begin a1[k] = a; b1[k] = b; ci1[k] = ci; v1[k] = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            got = acc_now[k] && (acc_who[k] == id);
        end
        chk("issue_accept", got, 1);
        if (!id) v0[k] = 1'b0; else v1[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, input int n, input int budget);
        for (int i = 0; i < budget && nrsp[k] < n; i++) cyc();
        chk("rsp_timeout", nrsp[k] >= n, 1);
    endtask

    initial begin
        int gotv;
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            v0[k] = 1'b0; v1[k] = 1'b0; a0[k] = 8'd0; b0[k] = 8'd0; ci0[k] = 1'b0;
            a1[k] = 8'd0; b1[k] = 8'd0; ci1[k] = 1'b0; rr[k] = 1'b1;
            nrsp[k] = 0; lg[k] = 1'b1; idle_exp[k] = 1'b1; prev_acc[k] = 1'b0;
            acc_now[k] = 1'b0; acc_who[k] = 1'b0; prev_add[k] = 17'd0;
        end
        // Both requesters of instance 0 valid from reset onwards.
        v0[0] = 1'b1; a0[0] = 8'h10; b0[0] = 8'h20; ci0[0] = 1'b0;
        v1[0] = 1'b1; a1[0] = 8'hF0; b1[0] = 8'h20; ci1[0] = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < N; k++) begin
            chk("rst_rsp_valid", rv[k], 0);
            chk("rst_rsp_id", rid[k], 0);
            chk("rst_rsp_s", rs[k], 0);
            chk("rst_rsp_co", rco[k], 0);
            chk("rst_add_a", aa[k], 0);
            chk("rst_add_b", ab[k], 0);
            chk("rst_add_ci", aci[k], 0);
            chk("rst_busy", bsy[k], 0);
        end
        reset = 1'b0;

        wait_rsp(0, 4, 60);
        v0[0] = 1'b0; v1[0] = 1'b0;
        chk("grant_count", glog.size() >= 4, 1);
        if (glog.size() >= 4) begin
            chk("grant0", glog[0], 0);
            chk("grant1", glog[1], 1);
            chk("grant2", glog[2], 0);
            chk("grant3", glog[3], 1);
        end

        issue(0, 1'b0, 8'h7F, 8'h01, 1'b0);
        wait_rsp(0, 5, 20);
        chk("single_s", last_s[0], 8'h80);
        chk("single_co", last_co[0], 0);
        chk("single_id", last_id[0], 0);

        issue(0, 1'b1, 8'hFF, 8'h01, 1'b1);
        wait_rsp(0, 6, 20);
        chk("ovf_s", last_s[0], 8'h01);
        chk("ovf_co", last_co[0], 1);
        chk("ovf_id", last_id[0], 1);

        rr[0] = 1'b0;
        issue(0, 1'b0, 8'hA5, 8'h5A, 1'b1);
        v1[0] = 1'b1; a1[0] = 8'h33; b1[0] = 8'h44; ci1[0] = 1'b0;
        gotv = 0;
        for (int i = 0; i < 20 && gotv == 0; i++) begin
            cyc();
            if (rv[0]) gotv = 1;
        end
        chk("hold_reached_resp", gotv, 1);
        for (int i = 0; i < 5; i++) begin
            a1[0] = 8'($urandom_range(0, 255));
            b1[0] = 8'($urandom_range(0, 255));
            cyc();
            chk("hold_busy", bsy[0], 1);
            chk("hold_s", rs[0], 8'h00);
            chk("hold_co", rco[0], 1);
        end
        a1[0] = 8'h33; b1[0] = 8'h44;
        rr[0] = 1'b1;
        cyc();
        chk("idle_after_release", bsy[0], 0);
        gotv = 0;
        for (int i = 0; i < 10 && gotv == 0; i++) begin
            cyc();
            if (acc_now[0] && acc_who[0]) gotv = 1;
        end
        chk("req1_after_hold", gotv, 1);
        v1[0] = 1'b0;
        wait_rsp(0, 8, 20);
        chk("req1_after_hold_s", last_s[0], 8'h77);

        issue(0, 1'b0, 8'h11, 8'h22, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        v0[0] = 1'b1; a0[0] = 8'h40; b0[0] = 8'h02; ci0[0] = 1'b1;
        cyc();
        chk("accept_after_reset", acc_now[0] && !acc_who[0], 1);
        v0[0] = 1'b0;
        wait_rsp(0, 9, 20);
        chk("after_reset_s", last_s[0], 8'h43);

        issue(1, 1'b0, 8'hC3, 8'h3D, 1'b1);
        wait_rsp(1, 1, 10);
        chk("sc1_s", last_s[1], 8'h01);
        chk("sc1_co", last_co[1], 1);
        issue(2, 1'b0, 8'h80, 8'h80, 1'b0);
        wait_rsp(2, 1, 30);
        chk("sc15_s", last_s[2], 8'h00);
        chk("sc15_co", last_co[2], 1);
        for (int i = 0; i < 4; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
